// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one HD44780 LCD bus between two byte requesters.
// Optional feature macro: LCD_ARB_LOCK_EN (requester may lock the bus across bytes).
module lcd_bus_arbiter #(
  parameter int unsigned SETUP_CYCLES      = 32'd2,
  parameter int unsigned E_HIGH_CYCLES     = 32'd12,
  parameter int unsigned CMD_WAIT_CYCLES   = 32'd2000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 32'd82000
) (
  input  logic       CLOCK_50MHZ,
  input  logic       BUTTON_SOUTH,
  input  logic       REQ0_VALID,
  input  logic       REQ0_RS,
  input  logic [7:0] REQ0_DATA,
  input  logic       REQ0_LOCK,
  input  logic       REQ1_VALID,
  input  logic       REQ1_RS,
  input  logic [7:0] REQ1_DATA,
  input  logic       REQ1_LOCK,
  output logic       REQ0_READY,
  output logic       REQ1_READY,
  output logic [7:0] LCD_DATA_BIT,
  output logic       LCD_ENABLE,
  output logic       LCD_REGISTER_SELECT,
  output logic       LCD_READ_WRITE,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [31:0] SETUP_LAST = SETUP_CYCLES - 32'd1;
  localparam logic [31:0] E_LAST     = E_HIGH_CYCLES - 32'd1;
  localparam logic [31:0] CMD_LAST   = CMD_WAIT_CYCLES - 32'd1;
  localparam logic [31:0] CLEAR_LAST = CLEAR_WAIT_CYCLES - 32'd1;

  state_t      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        last_grant_q, last_grant_d;
  logic        clear_wait_q, clear_wait_d;
  logic [7:0]  lcd_data_q, lcd_data_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        lcd_enable_q, lcd_enable_d;
  logic        busy_q, busy_d;

  logic        rr0_s, rr1_s;
  logic        grant0_s, grant1_s;
  logic        hs_s, hs_sel_s;
  logic [7:0]  hs_data_s;
  logic        hs_rs_s;
  logic [31:0] hold_last_s;

  // Round-robin choice: the requester that did not win last time takes a tie.
  assign rr0_s = REQ0_VALID && (!REQ1_VALID || last_grant_q);
  assign rr1_s = REQ1_VALID && (!REQ0_VALID || !last_grant_q);

`ifdef LCD_ARB_LOCK_EN
  logic lock_active_q, lock_active_d;
  logic lock_id_q, lock_id_d;

  // Grant is restricted to the locked requester while a lock is held.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (lock_active_q) begin
      grant0_s = REQ0_VALID && !lock_id_q;
      grant1_s = REQ1_VALID && lock_id_q;
    end else begin
      grant0_s = rr0_s;
      grant1_s = rr1_s;
    end
  end

  // Lock is taken or released on every handshake from the winner's LOCK bit.
  always_comb begin
    lock_active_d = lock_active_q;
    lock_id_d     = lock_id_q;
    if (hs_s) begin
      lock_active_d = hs_sel_s ? REQ1_LOCK : REQ0_LOCK;
      lock_id_d     = hs_sel_s;
    end else begin
      lock_active_d = lock_active_q;
    end
  end

  always_ff @(posedge CLOCK_50MHZ or posedge BUTTON_SOUTH) begin
    if (BUTTON_SOUTH) begin
      lock_active_q <= 1'b0;
      lock_id_q     <= 1'b0;
    end else begin
      lock_active_q <= lock_active_d;
      lock_id_q     <= lock_id_d;
    end
  end
`else
  logic unused_lock_s;
  assign unused_lock_s = REQ0_LOCK ^ REQ1_LOCK;

  always_comb begin
    grant0_s = rr0_s;
    grant1_s = rr1_s;
  end
`endif

  // READY is gated by reset so nothing is offered while the button is held.
  assign REQ0_READY  = !BUTTON_SOUTH && (state_q == ST_IDLE) && grant0_s;
  assign REQ1_READY  = !BUTTON_SOUTH && (state_q == ST_IDLE) && grant1_s;
  assign hs_s        = REQ0_READY || REQ1_READY;
  assign hs_sel_s    = REQ1_READY;
  assign hs_data_s   = hs_sel_s ? REQ1_DATA : REQ0_DATA;
  assign hs_rs_s     = hs_sel_s ? REQ1_RS : REQ0_RS;
  assign hold_last_s = clear_wait_q ? CLEAR_LAST : CMD_LAST;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    clear_wait_d = clear_wait_q;
    lcd_data_d   = lcd_data_q;
    lcd_rs_d     = lcd_rs_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          state_d      = ST_SETUP;
          count_d      = 32'd0;
          last_grant_d = hs_sel_s;
          lcd_data_d   = hs_data_s;
          lcd_rs_d     = hs_rs_s;
          // Clear-display and return-home need the long post-write wait.
          clear_wait_d = !hs_rs_s && ((hs_data_s == 8'h01) || (hs_data_s == 8'h02));
        end else begin
          count_d = 32'd0;
        end
      end
      ST_SETUP: begin
        if (count_q == SETUP_LAST) begin
          state_d = ST_ENABLE;
          count_d = 32'd0;
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      ST_ENABLE: begin
        if (count_q == E_LAST) begin
          state_d = ST_HOLD;
          count_d = 32'd0;
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      ST_HOLD: begin
        if (count_q == hold_last_s) begin
          state_d = ST_IDLE;
          count_d = 32'd0;
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 32'd0;
      end
    endcase
    // E and BUSY are registered from the next state so they align with it.
    lcd_enable_d = (state_d == ST_ENABLE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLOCK_50MHZ or posedge BUTTON_SOUTH) begin
    if (BUTTON_SOUTH) begin
      state_q      <= ST_IDLE;
      count_q      <= 32'd0;
      last_grant_q <= 1'b1;
      clear_wait_q <= 1'b0;
      lcd_data_q   <= 8'h00;
      lcd_rs_q     <= 1'b0;
      lcd_enable_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      clear_wait_q <= clear_wait_d;
      lcd_data_q   <= lcd_data_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_enable_q <= lcd_enable_d;
      busy_q       <= busy_d;
    end
  end

  assign LCD_DATA_BIT        = lcd_data_q;
  assign LCD_REGISTER_SELECT = lcd_rs_q;
  assign LCD_ENABLE          = lcd_enable_q;
  assign LCD_READ_WRITE      = 1'b0;
  assign BUSY                = busy_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed self-checking bench for lcd_bus_arbiter; the long clear wait is
// shortened to 3000 cycles so the run stays short (still distinct from 2000).
module tb_lcd_bus_arbiter;

  localparam int CLEAR_W = 3000;
  localparam int BOUND   = 10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_valid, r0_rs, r0_lock, r1_valid, r1_rs, r1_lock;
  logic [7:0] r0_data, r1_data;
  logic       r0_ready, r1_ready;
  logic [7:0] lcd_data;
  logic       lcd_e, lcd_rs, lcd_rw, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] hs_data[$];
  int         hs_cyc[$];
  int         hs_req[$];
  int         hs_cnt[2];
  int         e_rise[$];
  int         e_len[$];
  logic [7:0] exp_bus = 8'h00;
  logic       exp_rs = 1'b0;
  logic       e_prev = 1'b0;
  int         e_start = 0;

  lcd_bus_arbiter #(.CLEAR_WAIT_CYCLES(CLEAR_W)) dut (
    .CLOCK_50MHZ(clk), .BUTTON_SOUTH(rst),
    .REQ0_VALID(r0_valid), .REQ0_RS(r0_rs), .REQ0_DATA(r0_data), .REQ0_LOCK(r0_lock),
    .REQ1_VALID(r1_valid), .REQ1_RS(r1_rs), .REQ1_DATA(r1_data), .REQ1_LOCK(r1_lock),
    .REQ0_READY(r0_ready), .REQ1_READY(r1_ready),
    .LCD_DATA_BIT(lcd_data), .LCD_ENABLE(lcd_e), .LCD_REGISTER_SELECT(lcd_rs),
    .LCD_READ_WRITE(lcd_rw), .BUSY(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus monitor: logs handshakes and E pulses, checks the bus while E is high.
  always @(negedge clk) begin
    #2;
    if (r0_ready || r1_ready) begin
      check("ready_onehot", {31'd0, r0_ready & r1_ready}, 32'd0);
      check("ready_only_idle", {31'd0, busy}, 32'd0);
    end
    if (r0_ready && r0_valid) begin
      hs_data.push_back(r0_data); hs_cyc.push_back(cyc); hs_req.push_back(0);
      hs_cnt[0]++; exp_bus = r0_data; exp_rs = r0_rs;
    end else if (r1_ready && r1_valid) begin
      hs_data.push_back(r1_data); hs_cyc.push_back(cyc); hs_req.push_back(1);
      hs_cnt[1]++; exp_bus = r1_data; exp_rs = r1_rs;
    end
    if (lcd_e) begin
      check("rw_low", {31'd0, lcd_rw}, 32'd0);
      check("e_data_stable", {24'd0, lcd_data}, {24'd0, exp_bus});
      check("e_rs_stable", {31'd0, lcd_rs}, {31'd0, exp_rs});
    end
    if (lcd_e && !e_prev) begin
      e_rise.push_back(cyc); e_start = cyc;
    end else if (!lcd_e && e_prev) begin
      e_len.push_back(cyc - e_start);
    end
    e_prev = lcd_e;
  end

  task automatic clear_logs();
    hs_data.delete(); hs_cyc.delete(); hs_req.delete();
    e_rise.delete(); e_len.delete();
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_data.size() < target && n < BOUND) begin
      @(negedge clk); #3; n++;
    end
    check("wait_hs_timeout", {31'd0, hs_data.size() >= target}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    #3;
    while (busy && n < BOUND) begin
      @(negedge clk); #3; n++;
    end
    check("wait_idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic send1(input logic rs, input logic [7:0] d, input logic lk);
    int target = hs_cnt[1] + 1;
    int n = 0;
    r1_rs = rs; r1_data = d; r1_lock = lk; r1_valid = 1'b1;
    while (hs_cnt[1] < target && n < BOUND) begin
      @(negedge clk); #3; n++;
    end
    check("send1_timeout", {31'd0, hs_cnt[1] >= target}, 32'd1);
    @(negedge clk);
    r1_valid = 1'b0;
  endtask

  task automatic do_reset();
    r0_valid = 1'b0; r1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic check_gap(input string tag, input int idx, input int exp);
    if (hs_cyc.size() > idx) check(tag, hs_cyc[idx] - hs_cyc[idx-1], exp);
    else check({tag, "_missing"}, hs_cyc.size(), idx + 1);
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b1; r0_rs = 1'b1; r0_data = 8'h11; r0_lock = 1'b0;
    r1_valid = 1'b0; r1_rs = 1'b0; r1_data = 8'h00; r1_lock = 1'b0;
    hs_cnt[0] = 0; hs_cnt[1] = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_data", {24'd0, lcd_data}, 32'd0);
    check("rst_e", {31'd0, lcd_e}, 32'd0);
    check("rst_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_rw", {31'd0, lcd_rw}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready0", {31'd0, r0_ready}, 32'd0);
    check("rst_ready1", {31'd0, r1_ready}, 32'd0);
    @(negedge clk);
    r0_valid = 1'b0; rst = 1'b0;

    // Reset in the middle of the E pulse.
    @(negedge clk);
    r0_rs = 1'b1; r0_data = 8'h55; r0_valid = 1'b1;
    wait_hs(1);
    r0_valid = 1'b0;
    check("t1_hs_data", {24'd0, hs_data[0]}, 32'h55);
    repeat (6) @(negedge clk);
    check("t1_e_high", {31'd0, lcd_e}, 32'd1);
    rst = 1'b1;
    #1;
    check("t1_rst_e", {31'd0, lcd_e}, 32'd0);
    check("t1_rst_busy", {31'd0, busy}, 32'd0);
    check("t1_rst_data", {24'd0, lcd_data}, 32'd0);
    check("t1_rst_rs", {31'd0, lcd_rs}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();

    // REQ0 only, function set 0x38: timing of E and handshake spacing.
    r0_rs = 1'b0; r0_data = 8'h38; r0_valid = 1'b1;
    wait_hs(2);
    r0_valid = 1'b0;
    check("t2_data0", {24'd0, hs_data[0]}, 32'h38);
    check("t2_data1", {24'd0, hs_data[1]}, 32'h38);
    check_gap("t2_gap", 1, 1 + 2 + 12 + 2000);
    check("t2_e_delay", e_rise[0] - hs_cyc[0], 32'd3);
    check("t2_e_len", e_len[0], 32'd12);
    wait_idle();
    clear_logs();

    // Clear (RS=0, 0x01) uses the long wait; data 0x01 does not.
    r0_rs = 1'b0; r0_data = 8'h01; r0_valid = 1'b1;
    wait_hs(2);
    r0_valid = 1'b0;
    check_gap("t3_clear_gap", 1, 1 + 2 + 12 + CLEAR_W);
    wait_idle();
    clear_logs();
    r0_rs = 1'b1; r0_data = 8'h01; r0_valid = 1'b1;
    wait_hs(2);
    r0_valid = 1'b0;
    check_gap("t3_data01_gap", 1, 1 + 2 + 12 + 2000);
    wait_idle();
    clear_logs();
    r0_rs = 1'b0; r0_data = 8'h02; r0_valid = 1'b1;
    wait_hs(2);
    r0_valid = 1'b0;
    check_gap("t3_home_gap", 1, 1 + 2 + 12 + CLEAR_W);
    wait_idle();

    // Both requesters valid: alternate, REQ0 first after reset.
    do_reset();
    r0_rs = 1'b1; r0_data = 8'h41; r0_lock = 1'b0; r0_valid = 1'b1;
    r1_rs = 1'b1; r1_data = 8'h42; r1_lock = 1'b0; r1_valid = 1'b1;
    wait_hs(4);
    r0_valid = 1'b0; r1_valid = 1'b0;
    check("t4_b0", {24'd0, hs_data[0]}, 32'h41);
    check("t4_b1", {24'd0, hs_data[1]}, 32'h42);
    check("t4_b2", {24'd0, hs_data[2]}, 32'h41);
    check("t4_b3", {24'd0, hs_data[3]}, 32'h42);
    check("t4_r0", hs_req[0], 32'd0);
    check("t4_r3", hs_req[3], 32'd1);
    check_gap("t4_gap", 2, 1 + 2 + 12 + 2000);
    wait_idle();

    // Lock sequence from REQ1 with REQ0 competing.
    do_reset();
    send1(1'b0, 8'h80, 1'b1);
    r0_rs = 1'b1; r0_data = 8'h5A; r0_lock = 1'b0; r0_valid = 1'b1;
    send1(1'b1, 8'h44, 1'b1);
    send1(1'b1, 8'h45, 1'b0);
    wait_hs(4);
    r0_valid = 1'b0;
    check("t5_b0", {24'd0, hs_data[0]}, 32'h80);
`ifdef LCD_ARB_LOCK_EN
    check("t5_b1", {24'd0, hs_data[1]}, 32'h44);
    check("t5_b2", {24'd0, hs_data[2]}, 32'h45);
    check("t5_b3", {24'd0, hs_data[3]}, 32'h5A);
`else
    check("t5_b1", {24'd0, hs_data[1]}, 32'h5A);
    check("t5_b2", {24'd0, hs_data[2]}, 32'h44);
    check("t5_b3", {24'd0, hs_data[3]}, 32'h5A);
`endif
    wait_idle();
    check("end_rw", {31'd0, lcd_rw}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
